// File: rtl/fetch_pkg.sv
// Shared types and helpers for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;

  localparam logic [31:0] NOP = 32'h8b1f03ff;

  // True when a byte address is word-aligned and inside a 2**aw-word ROM.
  function automatic logic in_rom(input logic [63:0] pc, input int aw);
    return (pc[1:0] == 2'b00) && ((pc >> (aw + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage controller: owns the PC, addresses the combinational imem, and
// feeds the IF/ID register toward decode with a valid/ready handshake.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          N        = 32,
  parameter int          AW       = 6,
  parameter int          PC_W     = 64,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [AW-1:0]   imem_addr,
  input  logic [N-1:0]    imem_q,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [N-1:0]    id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            fetch_fault,
  output logic [31:0]     fetch_cnt
);

  // state | meaning
  // IDLE  | first cycle after reset release, no fetch yet
  // RUN   | fetching sequentially from pc_q
  // FAULT | pc_q outside ROM or misaligned, waiting for a redirect
  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic            id_valid_q;
  logic [N-1:0]    id_instr_q;
  logic [PC_W-1:0] id_pc_q;
  logic            fault_q;
  logic [31:0]     cnt_q;

  logic xfer, load, pc_ok, redir_ok;

  assign xfer     = id_valid_q && id_ready;
  assign load     = !id_valid_q || id_ready;
  assign pc_ok    = in_rom(64'(pc_q), AW);
  assign redir_ok = in_rom(64'(redir_pc), AW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_W'(RESET_PC);
      id_valid_q <= 1'b0;
      id_instr_q <= N'(NOP);
      id_pc_q    <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // A transfer on the redirect edge still counts before the flush.
      if (xfer) cnt_q <= cnt_q + 32'd1;

      if (redir_valid && state_q != IDLE) begin
        pc_q       <= redir_pc;
        id_valid_q <= 1'b0;
        // Redirecting to an illegal target reports the fault right away.
        fault_q    <= !redir_ok;
        state_q    <= redir_ok ? RUN : FAULT;
      end else begin
        case (state_q)
          IDLE: state_q <= RUN;
          RUN: begin
            if (!pc_ok) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
              if (xfer) id_valid_q <= 1'b0;
            end else if (load) begin
              id_instr_q <= imem_q;
              id_pc_q    <= pc_q;
              id_valid_q <= 1'b1;
              pc_q       <= pc_q + PC_W'(4);
            end
          end
          FAULT: if (xfer) id_valid_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign imem_addr   = pc_q[AW+1:2];
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational ROM model beside it.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM word k holds 0xA000_0000 + k so every address is distinguishable.
  assign imem_q = 32'hA000_0000 | {26'b0, imem_addr};

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
  );

  function automatic logic [31:0] rom(input int unsigned byte_addr);
    return 32'hA000_0000 + byte_addr / 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input int unsigned pc,
                        input int unsigned cnt);
    chk({tag, "_valid"}, 64'(id_valid), 64'(v));
    if (v) begin
      chk({tag, "_pc"}, id_pc, 64'(pc));
      chk({tag, "_instr"}, 64'(id_instr), 64'(rom(pc)));
    end
    chk({tag, "_cnt"}, 64'(fetch_cnt), 64'(cnt));
  endtask

  initial begin
    reset = 1'b1; redir_valid = 1'b0; redir_pc = '0; id_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'h8b1f03ff);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    tick(); tick();
    reset = 1'b1;
    id_ready = 1'b1;

    tick();
    chk("idle_valid", 64'(id_valid), 64'd0);

    // Sequential streaming: id_pc 0..20, fifth transfer done when id_pc=20.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_if("seq", 1'b1, 4 * i, i);
    end

    // Stall three cycles on id_pc=20; pc stays at 24.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("stall", 1'b1, 20, 5);
      chk("stall_addr", 64'(imem_addr), 64'd6);
    end
    id_ready = 1'b1;
    tick(); chk_if("resume0", 1'b1, 24, 6);
    tick(); chk_if("resume1", 1'b1, 28, 7);

    // Redirect while stalled drops the held word.
    id_ready = 1'b0;
    tick(); chk_if("hold28", 1'b1, 28, 7);
    redir_valid = 1'b1; redir_pc = 64'h40;
    tick();
    chk_if("redir_flush", 1'b0, 0, 7);
    chk("redir_addr", 64'(imem_addr), 64'd16);
    redir_valid = 1'b0; id_ready = 1'b1;
    tick(); chk_if("redir_tgt", 1'b1, 64'h40, 7);

    // Redirect coinciding with a transfer: transfer counts, then flush.
    redir_valid = 1'b1; redir_pc = 64'hF0;
    tick(); chk_if("redir_xfer", 1'b0, 0, 8);
    redir_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_if("top", 1'b1, 32'hF0 + 4 * i, 8 + i);
    end
    chk("top_fault_pre", 64'(fetch_fault), 64'd0);

    // Sequential step past the last ROM word faults.
    tick();
    chk_if("wrap_fault", 1'b0, 0, 12);
    chk("wrap_fault_flag", 64'(fetch_fault), 64'd1);
    tick();
    chk_if("fault_hold", 1'b0, 0, 12);
    chk("fault_hold_flag", 64'(fetch_fault), 64'd1);

    redir_valid = 1'b1; redir_pc = 64'h0;
    tick();
    chk("fault_clear", 64'(fetch_fault), 64'd0);
    chk("fault_clear_valid", 64'(id_valid), 64'd0);
    redir_valid = 1'b0;
    tick(); chk_if("restart0", 1'b1, 0, 12);
    tick(); chk_if("restart1", 1'b1, 4, 13);

    // Misaligned redirect target goes straight to FAULT.
    redir_valid = 1'b1; redir_pc = 64'h102;
    tick();
    chk_if("misal", 1'b0, 0, 14);
    chk("misal_flag", 64'(fetch_fault), 64'd1);
    redir_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("misal_hold", 1'b0, 0, 14);
      chk("misal_hold_flag", 64'(fetch_fault), 64'd1);
    end

    // Asynchronous reset in the middle of a stall.
    redir_valid = 1'b1; redir_pc = 64'h20;
    tick();
    redir_valid = 1'b0; id_ready = 1'b0;
    tick(); chk_if("pre_rst", 1'b1, 32'h20, 14);
    tick();
    chk_if("pre_rst_hold", 1'b1, 32'h20, 14);
    chk("pre_rst_addr", 64'(imem_addr), 64'd9);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(id_valid), 64'd0);
    chk("mid_rst_instr", 64'(id_instr), 64'h8b1f03ff);
    chk("mid_rst_pc", id_pc, 64'd0);
    chk("mid_rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("mid_rst_fault", 64'(fetch_fault), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
